// File: rtl/gost89_core_arbiter.sv
// gost89_core_arbiter: round-robin arbiter/sequencer sharing one gost89_ecb core
// between NUM_REQ block requesters. One block in flight; results are tagged with
// the requester id. Optional watchdog: define GOST_ARB_TIMEOUT_EN.
module gost89_core_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 3,
  parameter int unsigned TIMEOUT = 40
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_mode,
  input  logic [64*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [63:0]             rsp_data,
  output logic                    core_reset,
  output logic                    core_mode,
  output logic                    core_load,
  output logic [63:0]             core_in,
  input  logic [63:0]             core_out,
  input  logic                    core_busy,
  output logic                    abort
);

  localparam int unsigned BLK_W = 64;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   grant_c;
  logic              found_c;
  logic              mode_c;
  logic [BLK_W-1:0]  data_c;
  logic              seen_busy;
  logic              cmpl_c;
  logic              exit_c;

  // Core finished its block, or the watchdog gave up on it.
  assign cmpl_c     = seen_busy & ~core_busy;
  assign exit_c     = cmpl_c | abort;
  assign core_reset = reset | abort;

  // Cyclic search for the first valid requester starting at ptr.
  always_comb begin : arb_search
    int unsigned idx;
    found_c = 1'b0;
    grant_c = '0;
    idx     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found_c && 1'(req_valid >> idx)) begin
        found_c = 1'b1;
        grant_c = ID_W'(idx);
      end
    end
  end

  // Mode and block of the candidate requester.
  always_comb begin
    mode_c = 1'(req_mode >> grant_c);
    data_c = BLK_W'(req_data >> {grant_c, 6'd0});
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found_c) state_nxt = LOAD;
      LOAD:    state_nxt = WAIT;
      WAIT:    if (exit_c) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    req_ready = '0;
    core_load = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      LOAD: begin
        core_load = 1'b1;
        req_ready = NUM_REQ'(1) << grant;
      end
      DONE:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Grant latch, core operands, round-robin pointer and result capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      grant     <= '0;
      core_mode <= 1'b0;
      core_in   <= '0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      seen_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found_c) begin
            grant     <= grant_c;
            core_mode <= mode_c;
            core_in   <= data_c;
          end
        end
        LOAD: begin
          seen_busy <= 1'b0;
          ptr       <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
        end
        WAIT: begin
          seen_busy <= seen_busy | core_busy;
          if (exit_c) begin
            rsp_id   <= grant;
            rsp_data <= abort ? '0 : core_out;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GOST_ARB_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  logic [TMR_W-1:0] tmr;

  // Watchdog: count cycles since LOAD and pulse abort once the limit is hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmr   <= '0;
      abort <= 1'b0;
    end else begin
      abort <= 1'b0;
      if (state == LOAD) begin
        tmr <= TMR_W'(1);
      end else if (state == WAIT) begin
        tmr <= tmr + TMR_W'(1);
        if (!abort && !cmpl_c && (tmr == TMR_W'(TIMEOUT - 1))) abort <= 1'b1;
      end
    end
  end
`else
  assign abort = 1'b0;

  // TIMEOUT only matters for the watchdog build.
  if (TIMEOUT == 0) begin : g_timeout_unused
  end
`endif

endmodule

// File: tb/tb_gost89_core_arbiter.sv
// Bench for gost89_core_arbiter: behavioural core stub, queue-driven requesters,
// and a round-robin scoreboard checked every cycle.
module tb_gost89_core_arbiter;

  localparam int NUM_REQ  = 2;
  localparam int ID_W     = 3;
  localparam int TIMEOUT  = 40;
  localparam int CORE_LAT = 32;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_mode;
  logic [64*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [63:0]           rsp_data;
  logic                  core_reset;
  logic                  core_mode;
  logic                  core_load;
  logic [63:0]           core_in;
  logic [63:0]           core_out;
  logic                  core_busy;
  logic                  abort;

  gost89_core_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_mode(req_mode), .req_data(req_data),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .core_reset(core_reset), .core_mode(core_mode), .core_load(core_load),
    .core_in(core_in), .core_out(core_out), .core_busy(core_busy),
    .abort(abort)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // GOST core with the team test key/sbox, reduced to its known vectors.
  function automatic logic [63:0] core_fn(input logic m, input logic [63:0] d);
    logic [64:0] k;
    k = {m, d};
    case (k)
      {1'b0, 64'hd5a8a608f4f115b4}: return 64'hd658a36b11cf46eb;
      {1'b1, 64'hd658a36b11cf46eb}: return 64'hd5a8a608f4f115b4;
      {1'b0, 64'h389eb44a391474c4}: return 64'h7aea1ed18e604249;
      {1'b1, 64'hc35472c91cd78640}: return 64'h379e59c3c96bb2ab;
      {1'b0, 64'h3f38ae3b8f541361}: return 64'h3b5834a000fba066;
      default:                      return d ^ 64'h0f0f_f0f0_3c3c_c3c3 ^ {63'd0, m};
    endcase
  endfunction

  // Core stub: busy for CORE_LAT cycles after load, result valid when busy drops.
  logic        stub_busy;
  logic        stub_mode;
  logic [63:0] stub_in;
  int          stub_cnt;
  logic        force_busy = 1'b0;

  always @(posedge clk or posedge core_reset) begin
    if (core_reset) begin
      stub_busy <= 1'b0;
      stub_cnt  <= 0;
      stub_mode <= 1'b0;
      stub_in   <= '0;
      core_out  <= '0;
    end else if (core_load) begin
      stub_in   <= core_in;
      stub_mode <= core_mode;
      stub_busy <= 1'b1;
      stub_cnt  <= CORE_LAT;
    end else if (stub_busy) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) begin
        stub_busy <= 1'b0;
        core_out  <= core_fn(stub_mode, stub_in);
      end
    end
  end

  assign core_busy = stub_busy | force_busy;

  // Requesters: each presents the head of its queue and pops it on accept.
  logic [64:0] q0[$];
  logic [64:0] q1[$];

  initial begin
    req_valid = '0;
    req_mode  = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (req_valid[0] && req_ready[0]) begin
        if (q0.size() > 0) void'(q0.pop_front());
        req_valid[0] = 1'b0;
      end
      if (req_valid[1] && req_ready[1]) begin
        if (q1.size() > 0) void'(q1.pop_front());
        req_valid[1] = 1'b0;
      end
      if (!req_valid[0] && q0.size() > 0) begin
        req_valid[0]     = 1'b1;
        req_mode[0]      = q0[0][64];
        req_data[63:0]   = q0[0][63:0];
      end
      if (!req_valid[1] && q1.size() > 0) begin
        req_valid[1]     = 1'b1;
        req_mode[1]      = q1[0][64];
        req_data[127:64] = q1[0][63:0];
      end
    end
  end

  function automatic int rr(input int p, input logic [NUM_REQ-1:0] v);
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (p + k) % NUM_REQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [63:0]     data;
  } rsp_t;

  rsp_t        exp_q[$];
  rsp_t        got_q[$];
  int          grant_log[$];
  int          ptr_m     = 0;
  int          cyc       = 0;
  int          acc_cyc   = -1000;
  int          rsp_cnt   = 0;
  int          abort_cnt = 0;
  logic        wd_blk    = 1'b0;
  logic [63:0] fl_data   = '0;
  logic        fl_mode   = 1'b0;

  // Scoreboard: round-robin grant prediction and response matching, every cycle.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_id",    64'(rsp_id),    64'd0);
        chk("rst_rsp_data",  rsp_data,       64'd0);
        chk("rst_core_load", 64'(core_load), 64'd0);
        chk("rst_core_mode", 64'(core_mode), 64'd0);
        chk("rst_core_in",   core_in,        64'd0);
        chk("rst_abort",     64'(abort),     64'd0);
        chk("rst_core_reset", 64'(core_reset), 64'd1);
        exp_q.delete();
        ptr_m  = 0;
        wd_blk = 1'b0;
      end else begin
        logic exp_abort;
        exp_abort = wd_blk && (cyc == acc_cyc + TIMEOUT);
        if (abort) abort_cnt++;
        chk("abort", 64'(abort), 64'(exp_abort));
        chk("core_reset", 64'(core_reset), 64'(exp_abort));
        chk("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
        if (req_ready != '0) begin
          int g;
          logic [NUM_REQ-1:0] oh;
          logic [63:0] res;
          g  = rr(ptr_m, req_valid);
          oh = '0;
          if (g >= 0) oh[g] = 1'b1;
          chk("grant", 64'(req_ready), 64'(oh));
          chk("core_load_on_accept", 64'(core_load), 64'd1);
          if (g >= 0) begin
            fl_data = req_data[64*g +: 64];
            fl_mode = req_mode[g];
            chk("core_in_on_load", core_in, fl_data);
            chk("core_mode_on_load", 64'(core_mode), 64'(fl_mode));
            res = force_busy ? 64'd0 : core_fn(fl_mode, fl_data);
            exp_q.push_back('{id: ID_W'(g), data: res});
            grant_log.push_back(g);
            ptr_m   = (g + 1) % NUM_REQ;
            acc_cyc = cyc;
            wd_blk  = force_busy;
          end
        end else begin
          chk("core_load_idle", 64'(core_load), 64'd0);
          if (exp_q.size() > 0) begin
            chk("core_in_stable", core_in, fl_data);
            chk("core_mode_stable", 64'(core_mode), 64'(fl_mode));
          end
        end
        if (rsp_valid) begin
          rsp_cnt++;
          got_q.push_back('{id: rsp_id, data: rsp_data});
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
          end else begin
            rsp_t e;
            e = exp_q.pop_front();
            chk("rsp_id", 64'(rsp_id), 64'(e.id));
            chk("rsp_data", rsp_data, e.data);
          end
        end
      end
    end
  end

  task automatic wait_rsp(input int target, input string name);
    int t;
    t = 0;
    while (rsp_cnt < target && t < 400) begin
      @(posedge clk);
      t++;
    end
    chk(name, 64'(rsp_cnt), 64'(target));
  endtask

  task automatic wait_acc(input int target, input string name);
    int t;
    t = 0;
    while (grant_log.size() < target && t < 400) begin
      @(posedge clk);
      t++;
    end
    chk(name, 64'(grant_log.size()), 64'(target));
  endtask

  task automatic pulse_reset(input int n);
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (n) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    int base;
    int gbase;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // Single encrypt on requester 0.
    base = rsp_cnt;
    q0.push_back({1'b0, 64'hd5a8a608f4f115b4});
    wait_rsp(base + 1, "enc_timeout");
    chk("enc_id",   64'(got_q[base].id), 64'd0);
    chk("enc_data", got_q[base].data,    64'hd658a36b11cf46eb);
    repeat (3) @(posedge clk);

    // Single decrypt on requester 1.
    base = rsp_cnt;
    q1.push_back({1'b1, 64'hd658a36b11cf46eb});
    wait_rsp(base + 1, "dec_timeout");
    chk("dec_id",   64'(got_q[base].id), 64'd1);
    chk("dec_data", got_q[base].data,    64'hd5a8a608f4f115b4);
    repeat (3) @(posedge clk);

    // Contention: both requests present when reset releases.
    @(posedge clk);
    #2 reset = 1'b1;
    q0.push_back({1'b0, 64'h389eb44a391474c4});
    q1.push_back({1'b1, 64'hc35472c91cd78640});
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    base = rsp_cnt;
    wait_rsp(base + 2, "cont_timeout");
    chk("cont_id0",   64'(got_q[base].id),     64'd0);
    chk("cont_data0", got_q[base].data,        64'h7aea1ed18e604249);
    chk("cont_id1",   64'(got_q[base + 1].id), 64'd1);
    chk("cont_data1", got_q[base + 1].data,    64'h379e59c3c96bb2ab);
    repeat (60) @(posedge clk);
    chk("cont_rsp_count", 64'(rsp_cnt), 64'(base + 2));

    // Fairness: both requesters continuously valid for six blocks.
    base  = rsp_cnt;
    gbase = grant_log.size();
    for (int i = 0; i < 3; i++) begin
      q0.push_back({1'b0, 64'h1111_0000_0000_0000 + 64'(i)});
      q1.push_back({1'b1, 64'h2222_0000_0000_0000 + 64'(i)});
    end
    wait_rsp(base + 6, "fair_timeout");
    for (int k = 0; k < 6; k++) begin
      if (grant_log.size() > gbase + k)
        chk("fair_order", 64'(grant_log[gbase + k]), 64'(k % 2));
      else
        chk("fair_missing", 64'(grant_log.size()), 64'(gbase + 6));
    end
    repeat (3) @(posedge clk);

    // Reset mid-operation drops the block; pointer restarts at 0.
    gbase = grant_log.size();
    q0.push_back({1'b0, 64'h0123456789abcdef});
    wait_acc(gbase + 1, "midrst_accept_timeout");
    repeat (7) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    base = rsp_cnt;
    repeat (60) @(posedge clk);
    chk("midrst_no_rsp", 64'(rsp_cnt), 64'(base));
    q0.push_back({1'b0, 64'h3f38ae3b8f541361});
    q1.push_back({1'b1, 64'hd658a36b11cf46eb});
    wait_rsp(base + 2, "midrst_timeout");
    chk("midrst_id0",   64'(got_q[base].id),     64'd0);
    chk("midrst_data0", got_q[base].data,        64'h3b5834a000fba066);
    chk("midrst_id1",   64'(got_q[base + 1].id), 64'd1);
    chk("midrst_data1", got_q[base + 1].data,    64'hd5a8a608f4f115b4);
    repeat (3) @(posedge clk);

`ifdef GOST_ARB_TIMEOUT_EN
    // Watchdog: core never finishes.
    base       = rsp_cnt;
    abort_cnt  = 0;
    force_busy = 1'b1;
    q0.push_back({1'b0, 64'hfeed_face_cafe_beef});
    wait_rsp(base + 1, "wd_timeout");
    chk("wd_abort_count", 64'(abort_cnt), 64'd1);
    chk("wd_id",   64'(got_q[base].id), 64'd0);
    chk("wd_data", got_q[base].data,    64'd0);
    force_busy = 1'b0;
    repeat (3) @(posedge clk);
`endif

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
